mmio_fifo_port: RTL and testbench

//  Memory-mapped bus responder on the shared LEGv8 address/data bus, alongside RAM_Detect and ROM_Detect.
//  The datapath pushes 64-bit words into a TX FIFO, which drains to an external valid/ready stream.
//  An external valid/ready stream fills an RX FIFO, which the datapath pops by loads.

---
 rtl/mmio_fifo_port_pkg.sv | 44 ++++
 rtl/mmio_fifo_port_sync_fifo.sv | 72 +++++++
 rtl/mmio_fifo_port.sv | 155 +++++++++++++++
 tb/tb_mmio_fifo_port.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mmio_fifo_port_pkg.sv
// Shared definitions for mmio_fifo_port: register indices, size encodings,
// STATUS/CONTROL bit positions and the access-size mask helper.
package mmio_fifo_port_pkg;

  localparam int unsigned BUS_W = 64;

  // Register index = byte offset >> 3
  localparam int unsigned REG_DATA_IDX    = 0;  // 0x00
  localparam int unsigned REG_STATUS_IDX  = 1;  // 0x08
  localparam int unsigned REG_CONTROL_IDX = 2;  // 0x10
  localparam int unsigned REG_IRQ_EN_IDX  = 3;  // 0x18

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'b00,
    SIZE_HALF   = 2'b01,
    SIZE_WORD   = 2'b10,
    SIZE_DOUBLE = 2'b11
  } size_e;

  localparam int unsigned ST_TX_FULL     = 0;
  localparam int unsigned ST_TX_EMPTY    = 1;
  localparam int unsigned ST_RX_FULL     = 2;
  localparam int unsigned ST_RX_EMPTY    = 3;
  localparam int unsigned ST_TX_OVERFLOW = 4;
  localparam int unsigned ST_RX_UNDERFLOW = 5;
  localparam int unsigned ST_TX_COUNT_LSB = 8;
  localparam int unsigned ST_RX_COUNT_LSB = 16;

  localparam int unsigned CTRL_CLEAR    = 0;
  localparam int unsigned CTRL_FLUSH_TX = 1;
  localparam int unsigned CTRL_FLUSH_RX = 2;

  function automatic logic [BUS_W-1:0] size_mask(input logic [1:0] sz);
    logic [BUS_W-1:0] m;
    case (sz)
      SIZE_BYTE: m = 64'h0000_0000_0000_00FF;
      SIZE_HALF: m = 64'h0000_0000_0000_FFFF;
      SIZE_WORD: m = 64'h0000_0000_FFFF_FFFF;
      default:   m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mmio_fifo_port_sync_fifo.sv
// Synchronous FIFO with flush; push while full is accepted only alongside a pop.
module mmio_fifo_port_sync_fifo #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic                  push_ok, pop_ok;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];

  // Flush overrides both sides; a full FIFO takes a push only if it pops too
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mmio_fifo_port.sv
// Bus-mapped TX/RX FIFO port with STATUS/CONTROL registers on the shared data bus.
// Define MMIO_FIFO_IRQ_EN to add the irq output and the IRQ_EN register at 0x18.
module mmio_fifo_port
  import mmio_fifo_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [63:0] data,
  input  logic [31:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [1:0]  size,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [63:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`ifdef MMIO_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 3;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic             hit_c, wr_c, rd_c;
  logic [IDX_W-1:0] reg_idx_c;
  logic [63:0]      wdata_c, rdata_c, status_c;
  logic             addr_unused;

  logic             tx_push_c, tx_pop_c, rx_pop_req_c, rx_push_c;
  logic             ctrl_we_c, clr_c, flush_tx_c, flush_rx_c;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic [63:0]      tx_head, rx_head;
  logic             tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

  assign hit_c       = (address[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
  assign reg_idx_c   = address[ADDR_WIDTH-1:3];
  assign addr_unused = ^address[2:0];
  assign wr_c        = hit_c && write_enable;
  assign rd_c        = hit_c && read_enable && !reset;
  assign wdata_c     = data & size_mask(size);

  assign tx_valid  = !tx_empty;
  assign tx_data   = tx_head;
  assign tx_pop_c  = tx_valid && tx_ready;
  assign rx_ready  = !rx_full && !reset;
  assign rx_push_c = rx_valid && rx_ready;

  // Register-access strobes
  always_comb begin
    tx_push_c    = 1'b0;
    rx_pop_req_c = 1'b0;
    ctrl_we_c    = 1'b0;
    if (wr_c && reg_idx_c == IDX_W'(REG_DATA_IDX))    tx_push_c    = 1'b1;
    if (wr_c && reg_idx_c == IDX_W'(REG_CONTROL_IDX)) ctrl_we_c    = 1'b1;
    if (rd_c && reg_idx_c == IDX_W'(REG_DATA_IDX))    rx_pop_req_c = 1'b1;
  end

  assign clr_c      = ctrl_we_c && wdata_c[CTRL_CLEAR];
  assign flush_tx_c = ctrl_we_c && wdata_c[CTRL_FLUSH_TX];
  assign flush_rx_c = ctrl_we_c && wdata_c[CTRL_FLUSH_RX];

  mmio_fifo_port_sync_fifo #(.WIDTH(64), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clock(clock), .reset(reset),
    .push(tx_push_c), .push_data(wdata_c), .pop(tx_pop_c), .flush(flush_tx_c),
    .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_head)
  );

  mmio_fifo_port_sync_fifo #(.WIDTH(64), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clock(clock), .reset(reset),
    .push(rx_push_c), .push_data(rx_data), .pop(rx_pop_req_c), .flush(flush_rx_c),
    .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
  );

  // Sticky flags: a set in the same cycle as a clear wins
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_unf_d = rx_unf_q;
    if (clr_c) begin
      tx_ovf_d = 1'b0;
      rx_unf_d = 1'b0;
    end
    if (tx_push_c && tx_full && !tx_pop_c && !flush_tx_c) tx_ovf_d = 1'b1;
    if (rx_pop_req_c && rx_empty) rx_unf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

  always_comb begin
    status_c                  = '0;
    status_c[ST_TX_FULL]      = tx_full;
    status_c[ST_TX_EMPTY]     = tx_empty;
    status_c[ST_RX_FULL]      = rx_full;
    status_c[ST_RX_EMPTY]     = rx_empty;
    status_c[ST_TX_OVERFLOW]  = tx_ovf_q;
    status_c[ST_RX_UNDERFLOW] = rx_unf_q;
    status_c[ST_TX_COUNT_LSB +: 8] = 8'(tx_count);
    status_c[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
  end

`ifdef MMIO_FIFO_IRQ_EN
  logic       irq_en_we_c;
  logic [3:0] irq_en_q, irq_en_d;
  logic       irq_q, irq_d;

  assign irq_en_we_c = wr_c && reg_idx_c == IDX_W'(REG_IRQ_EN_IDX);
  assign irq         = irq_q;

  always_comb begin
    irq_en_d = irq_en_q;
    if (irq_en_we_c) irq_en_d = wdata_c[3:0];
    irq_d = |(irq_en_q & {rx_unf_q, tx_ovf_q, tx_empty, !rx_empty});
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
`endif

  // Read mux; an empty RX FIFO reads as zero
  always_comb begin
    rdata_c = '0;
    if (reg_idx_c == IDX_W'(REG_DATA_IDX) && !rx_empty) rdata_c = rx_head;
    else if (reg_idx_c == IDX_W'(REG_STATUS_IDX))       rdata_c = status_c;
`ifdef MMIO_FIFO_IRQ_EN
    else if (reg_idx_c == IDX_W'(REG_IRQ_EN_IDX))       rdata_c = 64'(irq_en_q);
`endif
    rdata_c = rdata_c & size_mask(size);
  end

  assign data = rd_c ? rdata_c : {64{1'bz}};

endmodule

// File: tb/tb_mmio_fifo_port.sv
// Directed bench for mmio_fifo_port; define MMIO_FIFO_IRQ_EN to also exercise irq.
module tb_mmio_fifo_port;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clock = 1'b0;
  logic        reset;
  wire  [63:0] data;
  logic [31:0] address;
  logic        write_enable, read_enable;
  logic [1:0]  size;
  logic [63:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [63:0] rx_data;
  logic        rx_valid, rx_ready;
  logic        tb_drv;
  logic [63:0] tb_wdata;
`ifdef MMIO_FIFO_IRQ_EN
  logic        irq;
`endif

  int n_pass  = 0;
  int n_total = 0;

  assign data = tb_drv ? tb_wdata : {64{1'bz}};

  always #5 clock = ~clock;

  mmio_fifo_port dut (
    .clock(clock), .reset(reset), .data(data), .address(address),
    .write_enable(write_enable), .read_enable(read_enable), .size(size),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef MMIO_FIFO_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic bus_write(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz);
    @(negedge clock);
    address = a; size = sz; tb_wdata = d; tb_drv = 1'b1; write_enable = 1'b1;
    @(posedge clock); #1;
    write_enable = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [1:0] sz, output logic [63:0] d);
    @(negedge clock);
    address = a; size = sz; read_enable = 1'b1;
    #1 d = data;
    @(posedge clock); #1;
    read_enable = 1'b0;
  endtask

  task automatic rx_send(input logic [63:0] d);
    @(negedge clock);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [63:0] r;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    n_total++; if (rx_ready !== 1'b0) $display("FAIL reset_rx_ready got %b exp 0", rx_ready); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b exp 0", tx_valid); else n_pass++;
    @(negedge clock); reset = 1'b0;
    bus_read(BASE + 32'h08, 2'b11, r);
    n_total++; if (r !== 64'hA) $display("FAIL reset_status got %h exp %h", r, 64'hA); else n_pass++;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL idle_tx_valid got %b exp 0", tx_valid); else n_pass++;
    // Only the bench drives the bus while no read is in progress
    @(negedge clock);
    address = BASE; tb_wdata = 64'h5A5A_A5A5_0F0F_F0F0; tb_drv = 1'b1;
    #1;
    n_total++; if (data !== 64'h5A5A_A5A5_0F0F_F0F0) $display("FAIL idle_bus got %h exp %h", data, 64'h5A5A_A5A5_0F0F_F0F0); else n_pass++;
    tb_drv = 1'b0;
  endtask

  task automatic test_tx_basic;
    bus_write(BASE, 64'h1122_3344_5566_7788, 2'b10);
    n_total++; if (tx_data !== 64'h5566_7788) $display("FAIL tx_word_data got %h exp %h", tx_data, 64'h5566_7788); else n_pass++;
    n_total++; if (tx_valid !== 1'b1) $display("FAIL tx_word_valid got %b exp 1", tx_valid); else n_pass++;
    @(negedge clock); tx_ready = 1'b1;
    @(posedge clock); #1; tx_ready = 1'b0;
    n_total++; if (tx_valid !== 1'b0) $display("FAIL tx_drain_valid got %b exp 0", tx_valid); else n_pass++;
  endtask

  task automatic test_tx_overflow;
    logic [63:0] r;
    for (int i = 1; i <= 9; i++) bus_write(BASE, 64'(i), 2'b11);
    bus_read(BASE + 32'h08, 2'b11, r);
    n_total++; if (r !== 64'h819) $display("FAIL ovf_status got %h exp %h", r, 64'h819); else n_pass++;
    n_total++; if (tx_data !== 64'h1) $display("FAIL ovf_head got %h exp %h", tx_data, 64'h1); else n_pass++;
    bus_write(BASE + 32'h10, 64'h1, 2'b11);
    bus_read(BASE + 32'h08, 2'b11, r);
    n_total++; if (r !== 64'h809) $display("FAIL ovf_clear got %h exp %h", r, 64'h809); else n_pass++;
    tx_ready = 1'b1;
    bus_write(BASE, 64'h99, 2'b11);
    tx_ready = 1'b0;
    bus_read(BASE + 32'h08, 2'b11, r);
    n_total++; if (r !== 64'h809) $display("FAIL full_push_pop got %h exp %h", r, 64'h809); else n_pass++;
    n_total++; if (tx_data !== 64'h2) $display("FAIL full_push_pop_head got %h exp %h", tx_data, 64'h2); else n_pass++;
    bus_write(BASE + 32'h10, 64'h2, 2'b00);
    bus_read(BASE + 32'h08, 2'b11, r);
    n_total++; if (r !== 64'hA) $display("FAIL tx_flush got %h exp %h", r, 64'hA); else n_pass++;
  endtask

  task automatic test_rx;
    logic [63:0] r;
    rx_send(64'hAB);
    rx_send(64'hCD);
    bus_read(BASE + 32'h08, 2'b11, r);
    n_total++; if (r !== 64'h2_0002) $display("FAIL rx_status got %h exp %h", r, 64'h2_0002); else n_pass++;
    bus_read(BASE, 2'b11, r);
    n_total++; if (r !== 64'hAB) $display("FAIL rx_first got %h exp %h", r, 64'hAB); else n_pass++;
    bus_read(BASE, 2'b11, r);
    n_total++; if (r !== 64'hCD) $display("FAIL rx_second got %h exp %h", r, 64'hCD); else n_pass++;
    bus_read(BASE, 2'b11, r);
    n_total++; if (r !== 64'h0) $display("FAIL rx_empty_read got %h exp 0", r); else n_pass++;
    bus_read(BASE + 32'h08, 2'b11, r);
    n_total++; if (r !== 64'h2A) $display("FAIL rx_underflow got %h exp %h", r, 64'h2A); else n_pass++;
    rx_send(64'h1234_5678_9ABC_DEF0);
    bus_read(BASE, 2'b01, r);
    n_total++; if (r !== 64'hDEF0) $display("FAIL rx_half_read got %h exp %h", r, 64'hDEF0); else n_pass++;
    bus_write(BASE + 32'h10, 64'h1, 2'b11);
    bus_read(BASE + 32'h08, 2'b11, r);
    n_total++; if (r !== 64'hA) $display("FAIL rx_clear got %h exp %h", r, 64'hA); else n_pass++;
  endtask

  task automatic test_decode;
    logic [63:0] r;
    bus_read(BASE + 32'h10, 2'b11, r);
    n_total++; if (r !== 64'h0) $display("FAIL control_read got %h exp 0", r); else n_pass++;
    bus_write(BASE + 32'h20, 64'h77, 2'b11);
    bus_write(BASE - 32'h8, 64'h77, 2'b11);
    n_total++; if (tx_valid !== 1'b0) $display("FAIL miss_write got %b exp 0", tx_valid); else n_pass++;
`ifndef MMIO_FIFO_IRQ_EN
    bus_write(BASE + 32'h18, 64'hF, 2'b11);
    bus_read(BASE + 32'h18, 2'b11, r);
    n_total++; if (r !== 64'h0) $display("FAIL irq_en_absent got %h exp 0", r); else n_pass++;
`endif
  endtask

  task automatic test_reset_midstream;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) rx_send(64'h100 + 64'(i));
    n_total++; if (rx_ready !== 1'b0) $display("FAIL rx_full_ready got %b exp 0", rx_ready); else n_pass++;
    bus_read(BASE + 32'h08, 2'b11, r);
    n_total++; if (r !== 64'h8_0006) $display("FAIL rx_full_status got %h exp %h", r, 64'h8_0006); else n_pass++;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    n_total++; if (rx_ready !== 1'b0) $display("FAIL rx_ready_in_reset got %b exp 0", rx_ready); else n_pass++;
    @(negedge clock); reset = 1'b0;
    #1;
    n_total++; if (rx_ready !== 1'b1) $display("FAIL rx_ready_after_reset got %b exp 1", rx_ready); else n_pass++;
    bus_read(BASE + 32'h08, 2'b11, r);
    n_total++; if (r !== 64'hA) $display("FAIL reset_discard got %h exp %h", r, 64'hA); else n_pass++;
  endtask

`ifdef MMIO_FIFO_IRQ_EN
  task automatic test_irq;
    logic [63:0] r;
    bus_write(BASE + 32'h18, 64'h1, 2'b11);
    bus_read(BASE + 32'h18, 2'b11, r);
    n_total++; if (r !== 64'h1) $display("FAIL irq_en_read got %h exp 1", r); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL irq_idle got %b exp 0", irq); else n_pass++;
    rx_send(64'h55);
    n_total++; if (irq !== 1'b0) $display("FAIL irq_early got %b exp 0", irq); else n_pass++;
    @(posedge clock); #1;
    n_total++; if (irq !== 1'b1) $display("FAIL irq_set got %b exp 1", irq); else n_pass++;
    bus_read(BASE, 2'b11, r);
    n_total++; if (irq !== 1'b1) $display("FAIL irq_hold got %b exp 1", irq); else n_pass++;
    @(posedge clock); #1;
    n_total++; if (irq !== 1'b0) $display("FAIL irq_clear got %b exp 0", irq); else n_pass++;
  endtask
`endif

  initial begin
    reset = 1'b1; address = '0; write_enable = 1'b0; read_enable = 1'b0; size = 2'b11;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; tb_drv = 1'b0; tb_wdata = '0;
    repeat (2) @(posedge clock);
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx();
    test_decode();
    test_reset_midstream();
`ifdef MMIO_FIFO_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
